// File: rtl/rv32_hazard_scoreboard_pkg.sv
// Purpose: shared definitions for the RV32I hazard scoreboard and the EX-stage forward decode.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package rv32_hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    // Forward-select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // One in-flight instruction as seen by the scoreboard.
    typedef struct packed {
        logic                  v;   // real instruction, not a bubble
        logic [REG_ADDR_W-1:0] rd;  // destination register
        logic                  rw;  // writes rd
        logic                  ld;  // is a load
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // True when this entry produces the register the consumer actually reads.
    // x0 is hard-wired to zero, so a write to it never produces anything.
    function automatic logic producer_hit(input entry_t e,
                                          input logic [REG_ADDR_W-1:0] rs,
                                          input logic use_rs);
        return use_rs && e.v && e.rw && (e.rd != X0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/rv32_hazard_track_pipe.sv
// Purpose: DEPTH-entry shadow shift register of in-flight destinations (entry 0 = EX).
// Latency: an entry pushed at an edge appears at index 0 right after it, advancing one index per cycle.
// Backpressure: none; shifts every cycle, a bubble is inserted whenever push is low.
// Ports: clk, rst (async, active-low), push/push_entry (ID instruction to track),
//        entries (flattened bus, entry k at bits [k*ENTRY_W +: ENTRY_W]).
module rv32_hazard_track_pipe
    import rv32_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_entry,
    output logic [DEPTH*ENTRY_W-1:0] entries
);

    entry_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= push ? push_entry : '0;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    always_comb begin
        entries = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries[k*ENTRY_W +: ENTRY_W] = pipe_q[k];
        end
    end

endmodule

// File: rtl/rv32_hazard_scoreboard.sv
// Purpose: forwarding selects, load-use stalls and branch flushes for the 5-stage RV32I pipe.
// Latency: selects/stalls/flushes are combinational in the same cycle; counters update at the edge.
// Backpressure: raises stall_if/stall_id (plus an ID/EX bubble) while a needed operand is not yet forwardable.
// Ports: clk, rst (async, active-low); id_* describe the instruction in ID; ex_branch_taken is the
//        EX redirect; outputs are stall/flush controls, fwd_a_sel/fwd_b_sel (0 = regfile,
//        k+1 = entry k) and saturating stall_cnt/flush_cnt.
module rv32_hazard_scoreboard
    import rv32_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH        = 3,
    parameter int LOAD_AVAIL   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int FWD_EN       = 1,
    parameter int CNT_W        = 32,
    localparam int W_SEL       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [W_SEL-1:0]      fwd_a_sel,
    output logic [W_SEL-1:0]      fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Inputs are qualified by reset so every output is quiet while rst is low.
    logic id_vld_g;
    logic br_g;
    assign id_vld_g = id_valid & rst;
    assign br_g     = ex_branch_taken & rst;

    logic [DEPTH*ENTRY_W-1:0] entries;
    entry_t                   ent [DEPTH];
    logic                     push;
    entry_t                   push_entry;

    assign push_entry = '{v: 1'b1, rd: id_rd, rw: id_regwrite, ld: id_is_load};

    rv32_hazard_track_pipe #(
        .DEPTH (DEPTH)
    ) u_track (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .entries    (entries)
    );

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent[k] = entries[k*ENTRY_W +: ENTRY_W];
        end
    end

    // Walk from the oldest entry to the youngest so the nearest producer
    // overwrites the select last. A load feeds a consumer once its select value
    // reaches LOAD_AVAIL; anything closer must wait. Without forwarding every
    // in-flight producer blocks, since the regfile write-then-read covers WB.
    logic [W_SEL-1:0] sel_a;
    logic [W_SEL-1:0] sel_b;
    logic             hazard;

    always_comb begin
        sel_a  = W_SEL'(FWD_SEL_RF);
        sel_b  = W_SEL'(FWD_SEL_RF);
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_vld_g && producer_hit(ent[k], id_rs1, id_use_rs1)) begin
                sel_a = W_SEL'(k + 1);
            end
            if (id_vld_g && producer_hit(ent[k], id_rs2, id_use_rs2)) begin
                sel_b = W_SEL'(k + 1);
            end
            if (id_vld_g && (producer_hit(ent[k], id_rs1, id_use_rs1) ||
                             producer_hit(ent[k], id_rs2, id_use_rs2))) begin
                if ((FWD_EN == 0) || (ent[k].ld && ((k + 1) < LOAD_AVAIL))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign fwd_a_sel = (FWD_EN != 0) ? sel_a : W_SEL'(FWD_SEL_RF);
    assign fwd_b_sel = (FWD_EN != 0) ? sel_b : W_SEL'(FWD_SEL_RF);

    // A redirect squashes the ID instruction, so it overrides any stall for it.
    assign stall_if    = hazard & ~br_g;
    assign stall_id    = hazard & ~br_g;
    assign flush_id_ex = hazard | br_g;

    assign push = id_vld_g & ~stall_id & ~flush_id_ex;

    // Extra cycles of IF/ID flush after the redirect cycle itself.
    logic [2:0] hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if (br_g) begin
            hold_q <= 3'(FLUSH_CYCLES - 1);
        end else if (hold_q != '0) begin
            hold_q <= hold_q - 3'd1;
        end
    end

    assign flush_if_id = br_g | (hold_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_id && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_g && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32_hazard_scoreboard.sv
// Purpose: self-checking bench for rv32_hazard_scoreboard in three configurations sharing one stimulus.
// Latency: inputs driven just after the rising edge, outputs compared on the falling edge.
// Backpressure: n/a (the bench tracks the stalls it provokes).
module tb_rv32_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_regwrite = 1'b0;
    logic       id_is_load = 1'b0;
    logic       ex_branch_taken = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  o_sif, o_sid, o_fif, o_fex;
    logic [1:0]  o_sa [3];
    logic [1:0]  o_sb [3];
    logic [31:0] o_sc [3];
    logic [31:0] o_fc [3];
    logic [3:0]  sc2, fc2;

    assign o_sc[2] = {28'd0, sc2};
    assign o_fc[2] = {28'd0, fc2};

    rv32_hazard_scoreboard u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .stall_if(o_sif[0]), .stall_id(o_sid[0]), .flush_if_id(o_fif[0]), .flush_id_ex(o_fex[0]),
        .fwd_a_sel(o_sa[0]), .fwd_b_sel(o_sb[0]), .stall_cnt(o_sc[0]), .flush_cnt(o_fc[0])
    );

    rv32_hazard_scoreboard #(.FLUSH_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .stall_if(o_sif[1]), .stall_id(o_sid[1]), .flush_if_id(o_fif[1]), .flush_id_ex(o_fex[1]),
        .fwd_a_sel(o_sa[1]), .fwd_b_sel(o_sb[1]), .stall_cnt(o_sc[1]), .flush_cnt(o_fc[1])
    );

    rv32_hazard_scoreboard #(.FWD_EN(0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
        .stall_if(o_sif[2]), .stall_id(o_sid[2]), .flush_if_id(o_fif[2]), .flush_id_ex(o_fex[2]),
        .fwd_a_sel(o_sa[2]), .fwd_b_sel(o_sb[2]), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: remembers what each configuration issued on each past cycle.
    // The producer k+1 cycles back is the one the consumer would forward from with select k+1.
    localparam int MD  = 3;
    localparam int MLA = 2;
    int     m_fcy [3] = '{1, 2, 1};
    bit     m_fe  [3] = '{1'b1, 1'b1, 1'b0};
    longint m_max [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

    typedef struct {
        bit       v;
        logic [4:0] rd;
        bit       rw;
        bit       ld;
    } rec_t;

    rec_t   hist [3][8];
    int     cyc = 0;
    int     last_br [3];
    longint m_sc [3];
    longint m_fcnt [3];
    bit     e_sif [3];
    bit     e_fif [3];
    bit     e_fex [3];
    int     e_sa [3];
    int     e_sb [3];

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 8; j++) hist[i][j] = '{1'b0, 5'd0, 1'b0, 1'b0};
            last_br[i] = -100;
            m_sc[i] = 0;
            m_fcnt[i] = 0;
        end
    endfunction

    function automatic void model_eval(input int i);
        bit   haz = 1'b0;
        bit   br;
        bit   ma;
        bit   mb;
        rec_t p;
        e_sa[i] = 0;
        e_sb[i] = 0;
        for (int k = MD - 1; k >= 0; k--) begin
            p  = hist[i][(cyc - 1 - k) & 7];
            ma = rst && id_valid && id_use_rs1 && p.v && p.rw && p.rd != 0 && p.rd == id_rs1;
            mb = rst && id_valid && id_use_rs2 && p.v && p.rw && p.rd != 0 && p.rd == id_rs2;
            if (ma && m_fe[i]) e_sa[i] = k + 1;
            if (mb && m_fe[i]) e_sb[i] = k + 1;
            if ((ma || mb) && (!m_fe[i] || (p.ld && (k + 1) < MLA))) haz = 1'b1;
        end
        br = rst && ex_branch_taken;
        e_fex[i] = br || haz;
        e_sif[i] = haz && !br;
        e_fif[i] = br || ((cyc - last_br[i]) < m_fcy[i]);
    endfunction

    function automatic void model_edge();
        bit issue;
        if (!rst) return;
        for (int i = 0; i < 3; i++) begin
            model_eval(i);
            issue = id_valid && !e_sif[i] && !e_fex[i];
            hist[i][cyc & 7] = '{issue, id_rd, id_regwrite, id_is_load};
            if (e_sif[i] && m_sc[i] < m_max[i]) m_sc[i]++;
            if (ex_branch_taken) begin
                if (m_fcnt[i] < m_max[i]) m_fcnt[i]++;
                last_br[i] = cyc;
            end
        end
        cyc++;
    endfunction

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            model_eval(i);
            chk($sformatf("c%0d stall_if", i),    32'(o_sif[i]), 32'(e_sif[i]));
            chk($sformatf("c%0d stall_id", i),    32'(o_sid[i]), 32'(e_sif[i]));
            chk($sformatf("c%0d flush_if_id", i), 32'(o_fif[i]), 32'(e_fif[i]));
            chk($sformatf("c%0d flush_id_ex", i), 32'(o_fex[i]), 32'(e_fex[i]));
            chk($sformatf("c%0d fwd_a_sel", i),   32'(o_sa[i]),  32'(e_sa[i]));
            chk($sformatf("c%0d fwd_b_sel", i),   32'(o_sb[i]),  32'(e_sb[i]));
            chk($sformatf("c%0d stall_cnt", i),   o_sc[i],       32'(m_sc[i]));
            chk($sformatf("c%0d flush_cnt", i),   o_fc[i],       32'(m_fcnt[i]));
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        check_model();
    endtask

    task automatic to_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit rw, input bit ld, input bit br);
        id_valid = v;
        id_rs1 = 5'(rs1);
        id_rs2 = 5'(rs2);
        id_use_rs1 = u1;
        id_use_rs2 = u2;
        id_rd = 5'(rd);
        id_regwrite = rw;
        id_is_load = ld;
        ex_branch_taken = br;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit ld; bit br;
        bit x_stall; bit x_fif; bit x_fex; int x_sa; int x_sb;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // v rs1 rs2 u1 u2 rd rw ld br | stall fif fex sa sb   (default configuration)
        tbl[0]  = '{1, 1, 2,  1, 1, 5,  1, 0, 0,  0, 0, 0, 0, 0};  // add x5
        tbl[1]  = '{1, 5, 1,  1, 1, 6,  1, 0, 0,  0, 0, 0, 1, 0};  // back-to-back
        tbl[2]  = '{1, 5, 3,  1, 1, 8,  1, 0, 0,  0, 0, 0, 2, 0};  // one between
        tbl[3]  = '{1, 5, 6,  1, 1, 9,  1, 0, 0,  0, 0, 0, 3, 2};  // two between / x6
        tbl[4]  = '{1, 1, 9,  1, 0, 10, 1, 1, 0,  0, 0, 0, 0, 0};  // lw x10, rs2 unused
        tbl[5]  = '{1, 1, 10, 1, 1, 11, 1, 0, 0,  1, 0, 1, 0, 1};  // load-use stall
        tbl[6]  = '{1, 1, 10, 1, 1, 11, 1, 0, 0,  0, 0, 0, 0, 2};  // then forward
        tbl[7]  = '{1, 1, 2,  1, 1, 0,  1, 0, 0,  0, 0, 0, 0, 0};  // writes x0
        tbl[8]  = '{1, 0, 0,  1, 1, 5,  1, 0, 0,  0, 0, 0, 0, 0};  // reads x0
        tbl[9]  = '{1, 1, 1,  1, 1, 5,  1, 0, 0,  0, 0, 0, 0, 0};  // second x5
        tbl[10] = '{1, 5, 5,  1, 1, 12, 1, 0, 0,  0, 0, 0, 1, 1};  // nearest wins
        tbl[11] = '{1, 1, 2,  1, 1, 13, 1, 1, 0,  0, 0, 0, 0, 0};  // lw x13
        tbl[12] = '{1, 13, 0, 1, 1, 14, 1, 0, 1,  0, 1, 1, 1, 0};  // branch beats load-use
        tbl[13] = '{0, 13, 0, 1, 1, 14, 1, 0, 0,  0, 0, 0, 0, 0};  // bubble

        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset c%0d stall_id", i), 32'(o_sid[i]), 32'd0);
            chk($sformatf("reset c%0d flush_if_id", i), 32'(o_fif[i]), 32'd0);
            chk($sformatf("reset c%0d stall_cnt", i), o_sc[i], 32'd0);
        end
        do_reset();

        for (int r = 0; r < 14; r++) begin
            set_id(tbl[r].v, tbl[r].rs1, tbl[r].rs2, tbl[r].u1, tbl[r].u2,
                   tbl[r].rd, tbl[r].rw, tbl[r].ld, tbl[r].br);
            to_neg();
            chk($sformatf("tbl%0d stall_id", r),    32'(o_sid[0]), 32'(tbl[r].x_stall));
            chk($sformatf("tbl%0d stall_if", r),    32'(o_sif[0]), 32'(tbl[r].x_stall));
            chk($sformatf("tbl%0d flush_if_id", r), 32'(o_fif[0]), 32'(tbl[r].x_fif));
            chk($sformatf("tbl%0d flush_id_ex", r), 32'(o_fex[0]), 32'(tbl[r].x_fex));
            chk($sformatf("tbl%0d fwd_a_sel", r),   32'(o_sa[0]),  32'(tbl[r].x_sa));
            chk($sformatf("tbl%0d fwd_b_sel", r),   32'(o_sb[0]),  32'(tbl[r].x_sb));
            to_edge();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("tbl stall_cnt", o_sc[0], 32'd1);
        chk("tbl flush_cnt", o_fc[0], 32'd1);
        to_edge();

        // Taken branch on top of a load-use hazard, two-cycle IF/ID flush.
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1, 0);
        to_neg();
        to_edge();
        set_id(1, 1, 5, 1, 1, 7, 1, 0, 1);
        to_neg();
        chk("br+lu stall_id", 32'(o_sid[1]), 32'd0);
        chk("br+lu stall_if", 32'(o_sif[1]), 32'd0);
        chk("br+lu flush_if_id c0", 32'(o_fif[1]), 32'd1);
        chk("br+lu flush_id_ex c0", 32'(o_fex[1]), 32'd1);
        to_edge();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("br+lu flush_if_id c1", 32'(o_fif[1]), 32'd1);
        chk("br+lu flush_id_ex c1", 32'(o_fex[1]), 32'd0);
        to_edge();
        to_neg();
        chk("br+lu flush_if_id c2", 32'(o_fif[1]), 32'd0);
        chk("br+lu flush_cnt", o_fc[1], 32'd1);
        chk("br+lu stall_cnt", o_sc[1], 32'd0);
        to_edge();

        // Stall-only: consumer waits for the producer to leave all three entries.
        do_reset();
        set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
        to_neg();
        to_edge();
        set_id(1, 5, 0, 1, 1, 6, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk($sformatf("nofwd stall cyc%0d", c), 32'(o_sid[2]), 32'd1);
            chk($sformatf("nofwd sel_a cyc%0d", c), 32'(o_sa[2]), 32'd0);
            chk($sformatf("nofwd sel_b cyc%0d", c), 32'(o_sb[2]), 32'd0);
            to_edge();
        end
        to_neg();
        chk("nofwd issue", 32'(o_sid[2]), 32'd0);
        to_edge();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("nofwd stall_cnt", o_sc[2], 32'd3);
        to_edge();

        // Drive the narrow counter into saturation, then reset in the middle of a stall.
        for (int r = 0; r < 5; r++) begin
            set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
            to_neg();
            to_edge();
            set_id(1, 5, 0, 1, 1, 6, 1, 0, 0);
            repeat (4) begin
                to_neg();
                to_edge();
            end
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("sat stall_cnt", o_sc[2], 32'd15);
        to_edge();
        set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
        to_neg();
        to_edge();
        set_id(1, 5, 0, 1, 1, 6, 1, 0, 0);
        to_neg();
        chk("pre-rst stall", 32'(o_sid[2]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst c%0d stall_if", i), 32'(o_sif[i]), 32'd0);
            chk($sformatf("rst c%0d stall_id", i), 32'(o_sid[i]), 32'd0);
            chk($sformatf("rst c%0d flush_if_id", i), 32'(o_fif[i]), 32'd0);
            chk($sformatf("rst c%0d flush_id_ex", i), 32'(o_fex[i]), 32'd0);
            chk($sformatf("rst c%0d fwd_a_sel", i), 32'(o_sa[i]), 32'd0);
            chk($sformatf("rst c%0d fwd_b_sel", i), 32'(o_sb[i]), 32'd0);
            chk($sformatf("rst c%0d stall_cnt", i), o_sc[i], 32'd0);
            chk($sformatf("rst c%0d flush_cnt", i), o_fc[i], 32'd0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
        to_edge();
        set_id(1, 5, 0, 1, 1, 6, 1, 0, 0);
        to_neg();
        chk("post-rst fwd_a_sel", 32'(o_sa[0]), 32'd1);
        chk("post-rst no stall", 32'(o_sid[0]), 32'd0);
        chk("post-rst nofwd stall", 32'(o_sid[2]), 32'd1);
        to_edge();

        // Random traffic over a small register set so hazards are frequent.
        for (int n = 0; n < 3000; n++) begin
            set_id($urandom_range(0, 9) < 8,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0);
            to_neg();
            to_edge();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
